// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_sequencer
// Purpose  : Issues one SD command through the byte-wide register bus of the
//            SD host controller. The sequence is: clear the command ISR,
//            write the command and the argument (argument byte 0 last, since
//            it starts the command), wait a fixed gap, then poll the ISR
//            until complete/error or timeout. On success it reads resp0.
//            The result is then held on the rsp_* port until it is taken.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   POLL_TIMEOUT : polls made before the command is abandoned (rsp_timeout)
//   START_GAP    : idle cycles between the argument byte-0 write and the
//                  first poll
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : command request handshake (ready only in IDLE)
//   req_cmd, req_arg         : command / argument register values
//   rsp_valid/rsp_ready      : result handshake; result held until taken
//   rsp_isr                  : last cmd_isr byte 0 seen while polling
//   rsp_timeout              : poll budget exhausted without complete/error
//   rsp_data                 : resp0 register contents
//   reg_we, reg_addr,
//   reg_wdata, reg_rdata     : register-bus master (one access per cycle;
//                              reg_rdata is combinational from reg_addr)
// Configuration macro
//   SD_SEQ_AUTO_CLR_EN : when defined, cmd_isr byte 0 is cleared for one
//                        cycle (ACK state) after the result handshake.
// ============================================================================

// Register map fallbacks, used when sd_defines.h has not been included.
`ifndef CMD_REG_SIZE
`define CMD_REG_SIZE 14
`endif
`ifndef ARGUMENT
`define ARGUMENT 8'h00
`endif
`ifndef COMMAND
`define COMMAND 8'h04
`endif
`ifndef RESP0
`define RESP0 8'h08
`endif
`ifndef CMD_ISR
`define CMD_ISR 8'h34
`endif

module sd_cmd_sequencer #(
    parameter int POLL_TIMEOUT = 65535,
    parameter int START_GAP    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`CMD_REG_SIZE-1:0] req_cmd,
    input  logic [31:0]              req_arg,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_isr,
    output logic                     rsp_timeout,
    output logic [31:0]              rsp_data,
    output logic                     reg_we,
    output logic [6:0]               reg_addr,
    output logic [7:0]               reg_wdata,
    input  logic [7:0]               reg_rdata
);

    // Register byte offsets are word aligned, so the byte address is the
    // word part of the offset with the byte index in the two low bits.
    localparam logic [7:0] c_arg_off  = `ARGUMENT;
    localparam logic [7:0] c_cmd_off  = `COMMAND;
    localparam logic [7:0] c_resp_off = `RESP0;
    localparam logic [7:0] c_isr_off  = `CMD_ISR;

    localparam logic [6:0] c_isr_addr   = {c_isr_off[6:2],  2'd0};
    localparam logic [6:0] c_cmd0_addr  = {c_cmd_off[6:2],  2'd0};
    localparam logic [6:0] c_cmd1_addr  = {c_cmd_off[6:2],  2'd1};
    localparam logic [6:0] c_arg0_addr  = {c_arg_off[6:2],  2'd0};
    localparam logic [6:0] c_arg1_addr  = {c_arg_off[6:2],  2'd1};
    localparam logic [6:0] c_arg2_addr  = {c_arg_off[6:2],  2'd2};
    localparam logic [6:0] c_arg3_addr  = {c_arg_off[6:2],  2'd3};
    localparam logic [6:0] c_resp0_addr = {c_resp_off[6:2], 2'd0};
    localparam logic [6:0] c_resp1_addr = {c_resp_off[6:2], 2'd1};
    localparam logic [6:0] c_resp2_addr = {c_resp_off[6:2], 2'd2};
    localparam logic [6:0] c_resp3_addr = {c_resp_off[6:2], 2'd3};

    // Terminal counter values. The counter restarts at 0 on every state
    // change, so the last GAP cycle / last allowed poll is at value N-1.
    localparam logic [15:0] c_gap_last  = (START_GAP > 1) ? 16'(START_GAP - 1) : 16'd0;
    localparam logic [15:0] c_poll_last = (POLL_TIMEOUT > 65535) ? 16'hFFFF :
                                          (POLL_TIMEOUT > 1) ? 16'(POLL_TIMEOUT - 1) : 16'd0;

    typedef enum logic [3:0] {
        IDLE, CLR, CMD1, CMD0, ARG3, ARG2, ARG1, ARG0,
        GAP, POLL, RD0, RD1, RD2, RD3, DONE
`ifdef SD_SEQ_AUTO_CLR_EN
        , ACK
`endif
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [15:0]              r_cnt;
    logic [`CMD_REG_SIZE-1:0] r_cmd;
    logic [31:0]              r_arg;
    logic [7:0]               r_isr;
    logic                     r_timeout;
    logic [31:0]              r_data;
    logic [15:0]              w_cmd_ext;
    logic                     w_poll_hit;
    logic                     w_poll_tmo;

    // Command bits above the register width go out as zero.
    assign w_cmd_ext  = 16'(r_cmd);
    // Complete (bit 0) or error (bit 1) both end polling the same way.
    assign w_poll_hit = (r_state == POLL) && (reg_rdata[1:0] != 2'b00);
    assign w_poll_tmo = (r_cnt >= c_poll_last);

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == DONE);
    assign rsp_isr     = r_isr;
    assign rsp_timeout = r_timeout;
    assign rsp_data    = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        reg_we       = 1'b0;
        reg_addr     = c_isr_addr;
        reg_wdata    = 8'h00;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = CLR;
                end
            end
            CLR: begin
                reg_we       = 1'b1;
                w_state_next = CMD1;
            end
            CMD1: begin
                reg_we       = 1'b1;
                reg_addr     = c_cmd1_addr;
                reg_wdata    = w_cmd_ext[15:8];
                w_state_next = CMD0;
            end
            CMD0: begin
                reg_we       = 1'b1;
                reg_addr     = c_cmd0_addr;
                reg_wdata    = w_cmd_ext[7:0];
                w_state_next = ARG3;
            end
            ARG3: begin
                reg_we       = 1'b1;
                reg_addr     = c_arg3_addr;
                reg_wdata    = r_arg[31:24];
                w_state_next = ARG2;
            end
            ARG2: begin
                reg_we       = 1'b1;
                reg_addr     = c_arg2_addr;
                reg_wdata    = r_arg[23:16];
                w_state_next = ARG1;
            end
            ARG1: begin
                reg_we       = 1'b1;
                reg_addr     = c_arg1_addr;
                reg_wdata    = r_arg[15:8];
                w_state_next = ARG0;
            end
            ARG0: begin
                // Byte 0 starts the command in the controller.
                reg_we       = 1'b1;
                reg_addr     = c_arg0_addr;
                reg_wdata    = r_arg[7:0];
                w_state_next = (START_GAP > 0) ? GAP : POLL;
            end
            GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_next = POLL;
                end
            end
            POLL: begin
                if (w_poll_hit) begin
                    w_state_next = RD0;
                end else if (w_poll_tmo) begin
                    w_state_next = DONE;
                end
            end
            RD0: begin
                reg_addr     = c_resp0_addr;
                w_state_next = RD1;
            end
            RD1: begin
                reg_addr     = c_resp1_addr;
                w_state_next = RD2;
            end
            RD2: begin
                reg_addr     = c_resp2_addr;
                w_state_next = RD3;
            end
            RD3: begin
                reg_addr     = c_resp3_addr;
                w_state_next = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
`ifdef SD_SEQ_AUTO_CLR_EN
                    w_state_next = ACK;
`else
                    w_state_next = IDLE;
`endif
                end
            end
`ifdef SD_SEQ_AUTO_CLR_EN
            ACK: begin
                reg_we       = 1'b1;
                w_state_next = IDLE;
            end
`endif
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Shared gap / poll counter: restarts on every state change and
    // saturates so very large poll budgets cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_state_next != r_state) begin
            r_cnt <= 16'd0;
        end else if (((r_state == GAP) || (r_state == POLL)) && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Request latch and result capture. Result fields are cleared on accept
    // so a timed-out command never reports data from an earlier one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd     <= '0;
            r_arg     <= 32'd0;
            r_isr     <= 8'd0;
            r_timeout <= 1'b0;
            r_data    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_cmd     <= req_cmd;
                        r_arg     <= req_arg;
                        r_isr     <= 8'd0;
                        r_timeout <= 1'b0;
                        r_data    <= 32'd0;
                    end
                end
                POLL: begin
                    r_isr <= reg_rdata;
                    if (!w_poll_hit && w_poll_tmo) begin
                        r_timeout <= 1'b1;
                    end
                end
                RD0:     r_data[7:0]   <= reg_rdata;
                RD1:     r_data[15:8]  <= reg_rdata;
                RD2:     r_data[23:16] <= reg_rdata;
                RD3:     r_data[31:24] <= reg_rdata;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_sequencer
// Purpose  : Scoreboard bench for sd_cmd_sequencer. A register-slave model
//            raises cmd_isr a chosen number of polls after the command is
//            started; the reference model derives the expected bus writes,
//            result and latency from that poll count. A monitor compares
//            every bus write and every result cycle against the queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_sequencer;

    localparam int T = 20;
    localparam int G = 3;

    localparam logic [6:0] A_ISR0 = 7'h34;
    localparam logic [6:0] A_CMD1 = 7'h05;
    localparam logic [6:0] A_CMD0 = 7'h04;
    localparam logic [6:0] A_ARG3 = 7'h03;
    localparam logic [6:0] A_ARG2 = 7'h02;
    localparam logic [6:0] A_ARG1 = 7'h01;
    localparam logic [6:0] A_ARG0 = 7'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [13:0] req_cmd = 14'd0;
    logic [31:0] req_arg = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_isr;
    logic        rsp_timeout;
    logic [31:0] rsp_data;
    logic        reg_we;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;

    sd_cmd_sequencer #(.POLL_TIMEOUT(T), .START_GAP(G)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_arg(req_arg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_isr(rsp_isr), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
        .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        logic [7:0]  isr;
        logic        tmo;
        logic [31:0] data;
        int          done_cyc;
        int          rdcnt;
    } resp_t;

    wr_t   wq[$];
    resp_t rq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- register slave model ----------------
    logic [7:0]  sv_v = 8'h00;
    int          sv_p = 1;
    logic [31:0] sv_resp = 32'd0;
    logic [7:0]  isr_mem = 8'h00;
    logic        armed = 1'b0;
    int          s = 0;

    // s counts cycles since the argument byte-0 write; poll k (1-based)
    // happens at s = G + k - 1, so the status appears from poll sv_p on.
    always @(posedge clk) begin
        if (reg_we) begin
            if (reg_addr == A_ISR0) begin
                isr_mem <= reg_wdata;
                armed   <= 1'b0;
            end else if (reg_addr == A_ARG0) begin
                armed <= 1'b1;
                s     <= 0;
            end
        end else if (armed) begin
            s <= s + 1;
        end
    end

    always_comb begin
        reg_rdata = 8'h5A;
        if (reg_addr == A_ISR0)
            reg_rdata = (armed && (s >= G + sv_p - 1)) ? sv_v : isr_mem;
        else if (reg_addr[6:2] == 5'h02)
            reg_rdata = sv_resp[{reg_addr[1:0], 3'b000} +: 8];
    end

    // ---------------- monitor ----------------
    bit    mon_en = 1'b0;
    bit    prev_valid = 1'b0;
    int    rdcnt = 0;
    resp_t cur;
    wr_t   w;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (reg_we) begin
                    if (wq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", reg_addr, reg_wdata);
                    end else begin
                        w = wq.pop_front();
                        check("wr_addr", 32'(reg_addr), 32'(w.a));
                        check("wr_data", 32'(reg_wdata), 32'(w.d));
                    end
                end else if (reg_addr[6:2] == 5'h02) begin
                    rdcnt++;
                end else begin
                    check("idle_addr", 32'(reg_addr), 32'(A_ISR0));
                end
                if (rsp_valid && !prev_valid) begin
                    if (rq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got rsp_valid 1, required 0");
                    end else begin
                        cur = rq.pop_front();
                        check("rsp_latency", cyc, cur.done_cyc);
                        check("resp0_reads", rdcnt, cur.rdcnt);
                    end
                    rdcnt = 0;
                end
                if (rsp_valid) begin
                    check("rsp_isr", 32'(rsp_isr), 32'(cur.isr));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(cur.tmo));
                    if (!cur.tmo) check("rsp_data", rsp_data, cur.data);
                end
                prev_valid = rsp_valid;
            end
        end
    end

    // ---------------- driver / reference model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [13:0] cmd, input logic [31:0] arg,
                           input logic [7:0] v, input int p, input logic [31:0] resp,
                           input int hold, input bit abort);
        resp_t       e;
        int          n;
        int          k;
        bit          hit;
        logic [31:0] c32;
        k = 0;
        while (req_ready !== 1'b1 && k < 100) begin tick(); k++; end
        check("idle_before_req", 32'(req_ready), 32'd1);
        sv_v    = v;
        sv_p    = p;
        sv_resp = resp;
        c32     = 32'(cmd);
        wq.push_back('{A_ISR0, 8'h00});
        wq.push_back('{A_CMD1, c32[15:8]});
        wq.push_back('{A_CMD0, c32[7:0]});
        wq.push_back('{A_ARG3, arg[31:24]});
        wq.push_back('{A_ARG2, arg[23:16]});
        wq.push_back('{A_ARG1, arg[15:8]});
        wq.push_back('{A_ARG0, arg[7:0]});
        hit        = (p <= T);
        n          = hit ? p : T;
        e.isr      = hit ? v : 8'h00;
        e.tmo      = !hit;
        e.data     = resp;
        e.rdcnt    = hit ? 4 : 0;
        e.done_cyc = cyc + 1 + (1 + 2 + 4 + G + n + (hit ? 4 : 0));
        rq.push_back(e);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_arg   = arg;
        tick();
        req_valid = 1'b0;
        req_cmd   = 14'($urandom);
        req_arg   = $urandom;
        check("accept_ready_low", 32'(req_ready), 32'd0);
        if (abort) begin
            k = 0;
            while (!(reg_we && reg_addr == A_ARG2) && k < 50) begin tick(); k++; end
            check("arg2_reached", 32'(k < 50), 32'd1);
            rst = 1'b1;
            tick();
            check("abort_we", 32'(reg_we), 32'd0);
            check("abort_ready", 32'(req_ready), 32'd1);
            check("abort_valid", 32'(rsp_valid), 32'd0);
            wq.delete();
            rq.delete();
            rst = 1'b0;
            repeat (10) tick();
            return;
        end
        k = 0;
        while (rsp_valid !== 1'b1 && k < 300) begin tick(); k++; end
        if (k >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_wait: got no rsp_valid in 300 cycles, required rsp_valid");
            rst = 1'b1;
            tick();
            wq.delete();
            rq.delete();
            rst = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (hold >= 2 && i == hold / 2) begin
                req_valid = 1'b1;
                check("busy_ready_low", 32'(req_ready), 32'd0);
            end
            tick();
            req_valid = 1'b0;
        end
`ifdef SD_SEQ_AUTO_CLR_EN
        wq.push_back('{A_ISR0, 8'h00});
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_released", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'(A_ISR0));
        check("rst_rsp_isr", 32'(rsp_isr), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // complete after 10 polls
        run_txn(14'h0119, 32'hDEADBEEF, 8'h01, 10, 32'h1234_5678, 1, 1'b0);
        // complete and error together, seen on the first poll
        run_txn(14'h2A55, 32'h0BAD_F00D, 8'h03, 1, 32'hCAFE_0001, 0, 1'b0);
        // status arriving on the very last allowed poll
        run_txn(14'h3FFF, 32'h8000_0001, 8'h02, T, 32'hA5A5_5A5A, 2, 1'b0);
        // never completes within budget
        run_txn(14'h0001, 32'h1111_2222, 8'h01, T + 1, 32'h9999_9999, 0, 1'b0);
        // reset while writing argument byte 2
        run_txn(14'h0C0C, 32'h4433_2211, 8'h01, 5, 32'h7777_7777, 0, 1'b1);
        // result held for 50 cycles with a request pulse in the window
        run_txn(14'h1234, 32'h5566_7788, 8'hF1, 7, 32'h0F0F_F0F0, 50, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom);
            run_txn(14'($urandom), $urandom, {rb[7:2], 2'($urandom_range(1, 3))},
                    int'($urandom_range(1, T + 4)), $urandom,
                    int'($urandom_range(0, 4)), 1'b0);
        end

        repeat (5) tick();
        check("writes_drained", wq.size(), 0);
        check("rsp_drained", rq.size(), 0);
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        check("final_rst_rsp_data", rsp_data, 32'd0);
        check("final_rst_rsp_isr", 32'(rsp_isr), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_sequencer.md
SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 65535: maximum number of POLL cycles before the command is aborted.
REQ-002 SHALL have parameter START_GAP, default 16: idle cycles after the argument byte-0 write and before the first poll.
REQ-003 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock, the same clock as the register-bus slave.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  a command request is presented.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_cmd  in  `CMD_REG_SIZE  value for the command register.
REQ-009 req_arg  in  32  value for the argument register.
REQ-010 rsp_valid  out  1  result available; held until rsp_ready.
REQ-011 rsp_ready  in  1  result consumed.
REQ-012 rsp_isr  out  8  last cmd_isr byte 0 read during POLL.
REQ-013 rsp_timeout  out  1  poll timeout occurred.
REQ-014 rsp_data  out  32  resp0 register contents.
REQ-015 reg_we  out  1  register-bus write strobe.
REQ-016 reg_addr  out  7  byte address, formed as {register offset from sd_defines.h, byte index}.
REQ-017 reg_wdata  out  8  write byte.
REQ-018 reg_rdata  in  8  read byte; combinational from reg_addr in the same cycle.

Function
REQ-019 States SHALL be IDLE, CLR, CMD1, CMD0, ARG3, ARG2, ARG1, ARG0, GAP, POLL, RD0, RD1, RD2, RD3, DONE, plus ACK (only when SD_SEQ_AUTO_CLR_EN is defined).
REQ-020 req_ready SHALL be high only in IDLE; on handshake, req_cmd and req_arg SHALL be latched and the block SHALL go to CLR.
REQ-021 CLR SHALL drive one cycle of reg_we=1 at `cmd_isr byte 0 with reg_wdata=0 to clear stale status.
REQ-022 CMD1 and CMD0 SHALL write command bytes 1 then 0, one per cycle; bits above `CMD_REG_SIZE SHALL be written as zero.
REQ-023 ARG3..ARG0 SHALL write argument bytes 3,2,1,0 in that order, one per cycle; byte 0 SHALL be written last because it triggers cmd_start.
REQ-024 GAP SHALL hold reg_we=0 for exactly START_GAP cycles and then enter POLL.
REQ-025 POLL SHALL address `cmd_isr byte 0 every cycle with reg_we=0 and capture reg_rdata into rsp_isr.
REQ-026 POLL SHALL exit to RD0 when the captured bit 0 (complete) or bit 1 (error) is set; if both are set the exit SHALL be the same.
REQ-027 The POLL counter SHALL be 16 bits and SHALL saturate; when it reaches POLL_TIMEOUT with no exit condition, the block SHALL set rsp_timeout=1 and go to DONE, skipping RD0..RD3.
REQ-028 RD0..RD3 SHALL read `resp0 bytes 0..3 in consecutive cycles into rsp_data[7:0]..[31:24].
REQ-029 In DONE, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be stable; on rsp_ready the block SHALL go to ACK if SD_SEQ_AUTO_CLR_EN is defined, otherwise to IDLE.
REQ-030 Outside write states, reg_we SHALL be 0 and reg_addr SHALL be `cmd_isr byte 0.
REQ-031 A req_valid arriving while the block is busy SHALL be ignored until the block returns to IDLE; there is no queueing.
REQ-032 The block SHALL issue at most one register access per cycle.
REQ-033 Uninterrupted latency from accept to rsp_valid SHALL be 1+2+4+START_GAP+N_poll+4 cycles.

Reset
REQ-034 On rst: state=IDLE, req_ready=1, rsp_valid=0, rsp_isr=0, rsp_timeout=0, rsp_data=0, reg_we=0, and the poll counter cleared.
REQ-035 rst asserted mid-sequence SHALL abort in the next cycle with no further bus writes; partially written registers SHALL be left as they are.

Configuration
REQ-036 Macro SD_SEQ_AUTO_CLR_EN: when defined, ACK SHALL write 0 to `cmd_isr byte 0 for one cycle after the rsp handshake and then go to IDLE.
REQ-037 Without SD_SEQ_AUTO_CLR_EN, the ACK state SHALL be absent and status SHALL remain in cmd_isr until the next CLR.

Verification
REQ-038 Scenario: req_cmd=0x0119, req_arg=0xDEADBEEF, and the slave model sets isr=0x01 after 10 polls -> writes occur in order isr0, cmd1=0x01, cmd0=0x19, arg3=0xDE, arg2=0xAD, arg1=0xBE, arg0=0xEF; rsp_isr=0x01; rsp_data equals the model's resp0; rsp_timeout=0.
REQ-039 Scenario: the model sets isr=0x03 -> the block exits POLL on the first poll that sees it; rsp_isr=0x03.
REQ-040 Scenario: isr stays 0 with POLL_TIMEOUT=20 -> rsp_valid is asserted after 20 polls; rsp_timeout=1; no resp0 reads occur.
REQ-041 Scenario: rst asserted during ARG2 -> reg_we=0 from the next cycle; req_ready=1; no arg0 write ever occurs.
REQ-042 Scenario: rsp_ready held low for 50 cycles -> rsp_valid and rsp_data are stable throughout; a req_valid pulse in that window is not accepted.
REQ-043 Scenario: with SD_SEQ_AUTO_CLR_EN defined -> exactly one isr0 write follows the rsp handshake; without the macro -> none.
